// File: rtl/dsm_pkg.sv
// Shared constants and FSM encoding for the DSS MAC sequencer.
package dsm_pkg;
    localparam int DATA_W    = 20;
    localparam int COEF_W    = 25;
    localparam int DATA_FRAC = 15;
    localparam int COEF_FRAC = 23;
    localparam int ACC_W     = 48;

    // Coefficient address map: A0[k] at ADDR_A0+k, C[k] at ADDR_C+k, D at ADDR_D.
    localparam logic [3:0] ADDR_A0 = 4'd0;
    localparam logic [3:0] ADDR_C  = 4'd4;
    localparam logic [3:0] ADDR_D  = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_MAC_X  = 3'd1,
        ST_MAC_Y  = 3'd2,
        ST_MAC_D  = 3'd3,
        ST_UPDATE = 3'd4
    } dsm_state_e;
endpackage

// File: rtl/dss_mac.sv
// Single multiply-accumulate unit: full-width product, 48-bit accumulator,
// result = saturate((acc >>> COEF_FRAC) + bias) to the DATA_W signed range.
// bias lets x0' add u after the shift without a second saturation stage.
module dss_mac
    import dsm_pkg::*;
#(
    parameter int DATA_W = dsm_pkg::DATA_W,
    parameter int COEF_W = dsm_pkg::COEF_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     enable,
    input  logic signed [COEF_W-1:0] coef,
    input  logic signed [DATA_W-1:0] data,
    input  logic signed [DATA_W-1:0] bias,
    output logic signed [DATA_W-1:0] result
);
    localparam int PROD_W = COEF_W + DATA_W;
    localparam logic signed [ACC_W-1:0] SAT_MAX = (ACC_W'(1) <<< (DATA_W - 1)) - ACC_W'(1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -(ACC_W'(1) <<< (DATA_W - 1));

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  addend;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;

    assign prod   = coef * data;
    assign addend = ACC_W'(prod);

    // Accumulator: clear+enable starts a new sum with the current product.
    always_ff @(posedge clk) begin
        if (reset)       acc <= '0;
        else if (clear)  acc <= enable ? addend : '0;
        else if (enable) acc <= acc + addend;
    end

    // Scale back to data format, add bias, clamp.
    always_comb begin
        sum = (acc >>> COEF_FRAC) + ACC_W'(bias);
        if (sum > SAT_MAX)      result = SAT_MAX[DATA_W-1:0];
        else if (sum < SAT_MIN) result = SAT_MIN[DATA_W-1:0];
        else                    result = sum[DATA_W-1:0];
    end
endmodule

// File: rtl/dss_mac_sequencer.sv
// DSS sequencer: one shared MAC computes x0' = A0.x + u and y = C.x + D.u,
// then shifts the companion-form state vector. Latency 2*NSTATE+2 cycles.
module dss_mac_sequencer
    import dsm_pkg::*;
#(
    parameter int NSTATE = 4,
    parameter int DATA_W = dsm_pkg::DATA_W,
    parameter int COEF_W = dsm_pkg::COEF_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_req,
    input  logic [DATA_W-1:0] u,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] y,
    output logic              overrun,
    input  logic              cfg_we,
    input  logic [3:0]        cfg_addr,
    input  logic [COEF_W-1:0] cfg_wdata,
    output logic              cfg_err
);
    localparam int              IDX_W = (NSTATE > 1) ? $clog2(NSTATE) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NSTATE - 1);
    localparam logic [3:0]      NS4  = 4'(NSTATE);

    dsm_state_e                     state;
    logic [IDX_W-1:0]               idx;
    logic [NSTATE-1:0][COEF_W-1:0]  a0;
    logic [NSTATE-1:0][COEF_W-1:0]  c_coef;
    logic [COEF_W-1:0]              d_coef;
    logic [NSTATE-1:0][DATA_W-1:0]  x;
    logic [DATA_W-1:0]              x0_nxt;
    logic [DATA_W-1:0]              u_q;

    logic [COEF_W-1:0] coef_sel;
    logic [DATA_W-1:0] data_sel;
    logic [DATA_W-1:0] bias_sel;
    logic [DATA_W-1:0] mac_result;
    logic              mac_clear;
    logic              mac_en;
    logic              x0_cap;
    logic [3:0]        c_off;

    assign busy   = (state != ST_IDLE);
    assign c_off  = cfg_addr - ADDR_C;
    // The A0 sum is complete in the first MAC_Y cycle; grab x0' then.
    assign x0_cap = (state == ST_MAC_Y) && (idx == '0);

    // Operand muxing for the shared MAC.
    always_comb begin
        coef_sel  = d_coef;
        data_sel  = u_q;
        bias_sel  = '0;
        mac_clear = 1'b0;
        mac_en    = 1'b0;
        case (state)
            ST_MAC_X: begin
                coef_sel  = a0[idx];
                data_sel  = x[idx];
                mac_clear = (idx == '0);
                mac_en    = 1'b1;
            end
            ST_MAC_Y: begin
                coef_sel  = c_coef[idx];
                data_sel  = x[idx];
                bias_sel  = x0_cap ? u_q : '0;
                mac_clear = (idx == '0);
                mac_en    = 1'b1;
            end
            ST_MAC_D: mac_en = 1'b1;
            default: ;
        endcase
    end

    dss_mac #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_mac (
        .clk    (clk),
        .reset  (reset),
        .clear  (mac_clear),
        .enable (mac_en),
        .coef   (coef_sel),
        .data   (data_sel),
        .bias   (bias_sel),
        .result (mac_result)
    );

    // Sequencer FSM, state vector, output register and status pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            idx     <= '0;
            u_q     <= '0;
            x0_nxt  <= '0;
            x       <= '0;
            y       <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            done    <= 1'b0;
            overrun <= sample_req && busy;
            if (x0_cap) x0_nxt <= mac_result;
            case (state)
                ST_IDLE: if (sample_req) begin
                    u_q   <= u;
                    idx   <= '0;
                    state <= ST_MAC_X;
                end
                ST_MAC_X: begin
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (idx == LAST) state <= ST_MAC_Y;
                end
                ST_MAC_Y: begin
                    idx <= (idx == LAST) ? '0 : idx + 1'b1;
                    if (idx == LAST) state <= ST_MAC_D;
                end
                ST_MAC_D: state <= ST_UPDATE;
                ST_UPDATE: begin
                    for (int k = 1; k < NSTATE; k++) x[k] <= x[k-1];
                    x[0]  <= x0_nxt;
                    y     <= mac_result;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Coefficient writes: only in IDLE and only to mapped addresses.
    always_ff @(posedge clk) begin
        if (reset) begin
            a0      <= '0;
            c_coef  <= '0;
            d_coef  <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            if (busy)
                cfg_err <= 1'b1;
            else if (cfg_addr >= ADDR_A0 && cfg_addr < ADDR_A0 + NS4)
                a0[cfg_addr[IDX_W-1:0]] <= cfg_wdata;
            else if (cfg_addr >= ADDR_C && cfg_addr < ADDR_C + NS4)
                c_coef[c_off[IDX_W-1:0]] <= cfg_wdata;
            else if (cfg_addr == ADDR_D)
                d_coef <= cfg_wdata;
            else
                cfg_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dss_mac_sequencer.sv
// Directed bench for dss_mac_sequencer with hand-computed expectations.
module tb_dss_mac_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sample_req = 1'b0;
    logic [19:0] u = '0;
    logic        busy, done, overrun, cfg_err;
    logic [19:0] y;
    logic        cfg_we = 1'b0;
    logic [3:0]  cfg_addr = '0;
    logic [24:0] cfg_wdata = '0;

    int n_tests = 0;
    int n_fail  = 0;
    int done_at, n_done, n_ovr, ovr_at, busy_mid, busy_rst, busy_done;

    dss_mac_sequencer #(.NSTATE(4), .DATA_W(20), .COEF_W(25)) dut (
        .clk(clk), .reset(reset), .sample_req(sample_req), .u(u),
        .busy(busy), .done(done), .y(y), .overrun(overrun),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
        .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [24:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(posedge clk);
        #1 cfg_we = 1'b0;
    endtask

    // One sample; optional injected request, reset and cfg write at cycle N
    // (cycle N = the Nth edge after the accepting edge; -1 = none, cfg 0 = same edge).
    task automatic run(input logic [19:0] uval, input int req_at, input int rst_at,
                       input int cfg_at, input logic [3:0] ca, input logic [24:0] cd);
        done_at = -1; n_done = 0; n_ovr = 0; ovr_at = -1;
        busy_mid = -1; busy_rst = -1; busy_done = -1;
        sample_req = 1'b1; u = uval;
        if (cfg_at == 0) begin cfg_we = 1'b1; cfg_addr = ca; cfg_wdata = cd; end
        @(posedge clk);
        #1 sample_req = 1'b0; u = '0; cfg_we = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            if (c == req_at) begin sample_req = 1'b1; u = 20'h12345; end
            if (c == rst_at) reset = 1'b1;
            if (c == cfg_at) begin cfg_we = 1'b1; cfg_addr = ca; cfg_wdata = cd; end
            @(posedge clk);
            #1 sample_req = 1'b0; reset = 1'b0; cfg_we = 1'b0;
            if (c == 1) busy_mid = int'(busy);
            if (c == rst_at) busy_rst = int'(busy);
            if (done) begin
                n_done++;
                if (done_at < 0) begin done_at = c; busy_done = int'(busy); end
            end
            if (overrun) begin n_ovr++; if (ovr_at < 0) ovr_at = c; end
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_y", y, 0);
        chk("rst_cfg_err", cfg_err, 0);

        // D=1.0, u=1.0 -> y=1.0 after 10 cycles
        wr(4'd8, 25'h0800000);
        run(20'h08000, -1, -1, -1, 4'd0, 25'd0);
        chk("lat_done_at", done_at, 10);
        chk("lat_n_done", n_done, 1);
        chk("lat_busy_mid", busy_mid, 1);
        chk("lat_busy_after", busy_done, 0);
        chk("lat_y", y, 20'h08000);

        // Four-sample delay through the state shift
        do_reset();
        wr(4'd7, 25'h0800000);
        for (int i = 1; i <= 5; i++) begin
            run(20'(i), -1, -1, -1, 4'd0, 25'd0);
            chk($sformatf("delay_y%0d", i), y, (i == 5) ? 1 : 0);
        end

        // Saturation
        do_reset();
        wr(4'd8, 25'h0FFFFFF);
        run(20'h7FFFF, -1, -1, -1, 4'd0, 25'd0);
        chk("sat_pos", y, 20'h7FFFF);
        run(20'h80000, -1, -1, -1, 4'd0, 25'd0);
        chk("sat_neg", y, 20'h80000);

        // Overrun: request 3 cycles into a computation
        do_reset();
        wr(4'd8, 25'h0800000);
        run(20'h01000, 3, -1, -1, 4'd0, 25'd0);
        chk("ovr_count", n_ovr, 1);
        chk("ovr_at", ovr_at, 3);
        chk("ovr_done_at", done_at, 10);
        chk("ovr_n_done", n_done, 1);
        chk("ovr_y", y, 20'h01000);

        // Coefficient write while busy is rejected
        do_reset();
        wr(4'd4, 25'h0800000);
        run(20'd50, -1, -1, -1, 4'd0, 25'd0);
        chk("cfgbusy_y0", y, 0);
        run(20'd60, -1, -1, 3, 4'd4, 25'h0400000);
        chk("cfgbusy_err", cfg_err, 1);
        chk("cfgbusy_y1", y, 50);
        run(20'd0, -1, -1, -1, 4'd0, 25'd0);
        chk("cfgbusy_y2", y, 60);

        // Reset mid-computation
        do_reset();
        run(20'd100, -1, -1, -1, 4'd0, 25'd0);
        run(20'd200, -1, -1, -1, 4'd0, 25'd0);
        run(20'd300, -1, 5, -1, 4'd0, 25'd0);
        chk("midrst_n_done", n_done, 0);
        chk("midrst_busy", busy_rst, 0);
        chk("midrst_y", y, 0);
        for (int k = 0; k < 4; k++) wr(4'(4 + k), 25'h0800000);
        run(20'd0, -1, -1, -1, 4'd0, 25'd0);
        chk("midrst_state_sum", y, 0);

        // Write and request together: new D applies
        do_reset();
        run(20'h08000, -1, -1, 0, 4'd8, 25'h0800000);
        chk("same_cyc_y", y, 20'h08000);
        chk("same_cyc_err", cfg_err, 0);

        // Unmapped address: ignored, sticky error
        do_reset();
        wr(4'd9, 25'h0800000);
        chk("bad_addr_err", cfg_err, 1);
        run(20'h08000, -1, -1, -1, 4'd0, 25'd0);
        chk("bad_addr_y", y, 0);
        chk("err_sticky", cfg_err, 1);
        do_reset();
        chk("err_cleared", cfg_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/dss_mac_sequencer.md
DSS_MAC_SEQUENCER -- requirements
Module: dss_mac_sequencer

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning), one per line:
  NSTATE  4   number of DSS states
  DATA_W  20  sample/state width, signed, 15 fractional bits
  COEF_W  25  coefficient width, signed, 23 fractional bits
REQ-002 The block SHALL have the following ports (name, direction, width, meaning), one per line:
  clk        in   1       clock
  reset      in   1       synchronous, active-high reset
  sample_req in   1       one-cycle pulse, new modulator sample available
  u          in   DATA_W  DSS input, sampled when sample_req is accepted
  busy       out  1       computation in progress
  done       out  1       one-cycle pulse, y valid
  y          out  DATA_W  DSS output, held until next done
  overrun    out  1       one-cycle pulse, sample_req dropped
  cfg_we     in   1       coefficient write strobe
  cfg_addr   in   4       coefficient address
  cfg_wdata  in   COEF_W  coefficient value
  cfg_err    out  1       sticky flag, write rejected
REQ-003 Reset SHALL be synchronous and active-high on reset; the clock SHALL be clk.

Function
REQ-004 The block SHALL time-multiplex one multiplier/accumulator to compute y = C·x + D·u and x0' = A0·x + u, with companion form x[k]' = x[k-1] for k = 1..NSTATE-1.
REQ-005 FSM states: IDLE, MAC_X (NSTATE cycles, A0[k]*x[k]), MAC_Y (NSTATE cycles, C[k]*x[k]), MAC_D (1 cycle, D*u), UPDATE (1 cycle).
REQ-006 IDLE -> MAC_X on sample_req; u is latched in the same cycle.
REQ-007 UPDATE SHALL shift the state vector, load x[0], register y, pulse done, and return to IDLE.
REQ-008 Latency SHALL be 2*NSTATE+2 cycles from the sample_req edge to the done edge (10 cycles at NSTATE=4).
REQ-009 busy SHALL be 1 in every state except IDLE.
REQ-010 A sample_req that arrives while busy=1 (UPDATE included) SHALL be dropped, SHALL pulse overrun in the next cycle, and SHALL leave the computation undisturbed.
REQ-011 Each product SHALL be formed at full width (COEF_W+DATA_W signed) and accumulated at 48 bits signed.
REQ-012 Each result SHALL be arithmetic-shifted right by 23 and then saturated to [-2^19, 2^19-1].
REQ-013 x0' SHALL add u after the shift and SHALL be saturated to the same range.
REQ-014 Coefficient address map: 0..3 = A0[0..3], 4..7 = C[0..3], 8 = D; writes to addresses 9..15 SHALL be ignored and SHALL set cfg_err.
REQ-015 A cfg_we accepted in IDLE SHALL take effect from the next cycle.
REQ-016 A cfg_we while busy=1 SHALL be ignored, SHALL set cfg_err, and SHALL leave the coefficient unchanged.
REQ-017 cfg_err SHALL clear only on reset.
REQ-018 If cfg_we and sample_req arrive together in IDLE, the write SHALL be applied, and the computation SHALL use the new coefficient.

Reset
REQ-019 Reset SHALL force: FSM to IDLE; busy, done, overrun and cfg_err to 0; y to 0; all state registers to 0; all coefficients to 0.
REQ-020 A reset asserted mid-computation SHALL abort it with no done pulse, and busy SHALL be 0 in the cycle after reset.

Structure
REQ-021 A shared package dsm_pkg SHALL hold DATA_W, COEF_W, the fractional-bit constants, the coefficient address constants and the FSM state enum.
REQ-022 The multiply-accumulate datapath SHALL be one sub-module, dss_mac (inputs: clear, enable, coef, data; output: saturated result), and the sequencer SHALL contain only the FSM, the coefficient and state registers, and the operand muxing.

Verification
REQ-023 After reset, write D=0x0800000 (1.0) and keep the other coefficients at 0, then pulse sample_req with u=0x08000 -> done exactly 10 cycles later, with y=0x08000 and busy low in the following cycle.
REQ-024 Set A0=0, C[3]=0x0800000 and D=0, then run samples u=1,2,3,4,5 -> y = 0,0,0,0,1 (a four-sample delay through the state shift).
REQ-025 Set D=0x0FFFFFF and drive u=0x7FFFF -> y=0x7FFFF (positive saturation); drive u=0x80000 -> y=0x80000 (negative saturation).
REQ-026 Pulse sample_req 3 cycles into a computation -> overrun pulses once, done occurs once at the original time, and y is unaffected.
REQ-027 Issue cfg_we to address 4 while busy -> cfg_err=1, C[0] unchanged, and the next result matches the old coefficient.
REQ-028 Assert reset 5 cycles into a computation -> no done pulse, y=0, and all state registers are 0.
